// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between NumReq
// requesters, with per-requester read response routing.
module sram_rr_arbiter #(
    parameter  int unsigned NumReq    = 4,
    parameter  int unsigned NumWords  = 256,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned Latency   = 1,
    localparam int unsigned AddrWidth =
        (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   =
        (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxWidth  =
        (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0]              we_i,
    input  logic [NumReq*AddrWidth-1:0]    addr_i,
    input  logic [NumReq*DataWidth-1:0]    wdata_i,
    input  logic [NumReq*BeWidth-1:0]      be_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic [NumReq-1:0]              rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [AddrWidth-1:0]           sram_addr_o,
    output logic [DataWidth-1:0]           sram_wdata_o,
    output logic [BeWidth-1:0]             sram_be_o,
    input  logic [DataWidth-1:0]           sram_rdata_i
);

    logic [IdxWidth-1:0]  ptr_q;
    logic [IdxWidth-1:0]  winner;
    logic                 any_gnt;
    logic                 oor;
    logic                 rd_issue;
    logic                 out_v;
    logic                 out_oor;
    logic [IdxWidth-1:0]  out_idx;

    logic [AddrWidth-1:0] addr_a  [NumReq];
    logic [DataWidth-1:0] wdata_a [NumReq];
    logic [BeWidth-1:0]   be_a    [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_a[g]  = addr_i[g*AddrWidth +: AddrWidth];
        assign wdata_a[g] = wdata_i[g*DataWidth +: DataWidth];
        assign be_a[g]    = be_i[g*BeWidth +: BeWidth];
    end

    // Scan from the pointer, wrapping, and take the first requester.
    always_comb begin
        int unsigned j;
        winner  = '0;
        any_gnt = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!any_gnt && req_i[IdxWidth'(j)]) begin
                any_gnt = 1'b1;
                winner  = IdxWidth'(j);
            end
        end
        if (!rst_ni) begin
            any_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (winner == IdxWidth'(NumReq - 1)) ?
                     '0 : winner + 1'b1;
        end
    end

    assign gnt_o = any_gnt ? (NumReq'(1) << winner) : '0;

    // A power-of-two depth can never be addressed out of range.
    if (NumWords == (1 << AddrWidth)) begin : g_no_oor
        assign oor = 1'b0;
    end else begin : g_oor
        assign oor = (32'(addr_a[winner]) >= NumWords);
    end

    assign sram_req_o   = any_gnt & ~oor;
    assign sram_we_o    = any_gnt & we_i[winner];
    assign sram_addr_o  = addr_a[winner];
    assign sram_wdata_o = wdata_a[winner];
    assign sram_be_o    = be_a[winner];

    assign rd_issue = any_gnt & ~we_i[winner];

    if (Latency == 0) begin : g_comb_rsp
        assign out_v   = rd_issue;
        assign out_idx = winner;
        assign out_oor = oor;
    end else begin : g_pipe_rsp
        logic [Latency-1:0]  v_q;
        logic [Latency-1:0]  oor_q;
        logic [IdxWidth-1:0] idx_q [Latency];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q   <= '0;
                oor_q <= '0;
                for (int i = 0; i < Latency; i++) begin
                    idx_q[i] <= '0;
                end
            end else begin
                v_q[0]   <= rd_issue;
                oor_q[0] <= oor;
                idx_q[0] <= winner;
                for (int i = 1; i < Latency; i++) begin
                    v_q[i]   <= v_q[i-1];
                    oor_q[i] <= oor_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end

        assign out_v   = v_q[Latency-1];
        assign out_idx = idx_q[Latency-1];
        assign out_oor = oor_q[Latency-1];
    end

    assign rvalid_o = (out_v && rst_ni) ?
                      (NumReq'(1) << out_idx) : '0;
    assign rdata_o  = (out_v && !out_oor && rst_ni) ?
                      sram_rdata_i : '0;

endmodule
